// File: rtl/tpu_pkg.sv
// Shared constants and types for the TPU v1 sequencer and its host decode.
package tpu_pkg;

  // Host address map (byte addresses, 8-byte aligned words)
  localparam logic [15:0] A_BASE      = 16'h0100;
  localparam logic [15:0] B_BASE      = 16'h0200;
  localparam logic [15:0] C_BASE      = 16'h0300;
  localparam logic [15:0] MATMUL_ADDR = 16'h0400;

  // Region masks: A and B are 8 rows of 8 bytes, C is 8 rows of two half-rows
  localparam logic [15:0] A_MASK = 16'hFFC0;
  localparam logic [15:0] B_MASK = 16'hFFC0;
  localparam logic [15:0] C_MASK = 16'hFF80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of RUN cycles needed to stream a full DIM x DIM product through the array
  function automatic int run_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/tpu_addr_decode.sv
// Combinational host-access decode: region hits, row/half selects and the MatMul trigger.
module tpu_addr_decode
  import tpu_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int ADDRW = 16
) (
  input  logic                   host_valid_i,
  input  logic                   r_w_i,
  input  logic [ADDRW-1:0]       addr_i,
  output logic                   a_wr_o,
  output logic                   b_wr_o,
  output logic                   c_rd_o,
  output logic                   trig_o,
  output logic                   mapped_o,
  output logic [$clog2(DIM)-1:0] arow_o,
  output logic [$clog2(DIM)-1:0] crow_o,
  output logic                   chalf_o
);

  localparam int ROWW = $clog2(DIM);

  logic in_a, in_b, in_c, in_mm;

  // Classify the address and qualify each region with direction and strobe
  always_comb begin
    in_a  = (addr_i & ADDRW'(A_MASK)) == ADDRW'(A_BASE);
    in_b  = (addr_i & ADDRW'(B_MASK)) == ADDRW'(B_BASE);
    in_c  = (addr_i & ADDRW'(C_MASK)) == ADDRW'(C_BASE);
    in_mm = addr_i == ADDRW'(MATMUL_ADDR);

    a_wr_o   = host_valid_i &  r_w_i & in_a;
    b_wr_o   = host_valid_i &  r_w_i & in_b;
    c_rd_o   = host_valid_i & ~r_w_i & in_c;
    trig_o   = host_valid_i &  r_w_i & in_mm;
    // Any touch of a live region counts, regardless of direction
    mapped_o = host_valid_i & (in_a | in_b | in_c | in_mm);

    arow_o  = '0;
    crow_o  = '0;
    chalf_o = 1'b0;
    if (a_wr_o) arow_o = addr_i[3 +: ROWW];
    if (c_rd_o) begin
      crow_o  = addr_i[4 +: ROWW];
      chalf_o = addr_i[3];
    end
  end

endmodule

// File: rtl/tpu_seq_ctrl.sv
// MatMul sequencer and host-access arbiter for the TPU v1 datapath.
module tpu_seq_ctrl
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_valid,
  input  logic                   r_w,
  input  logic [ADDRW-1:0]       addr,
  output logic                   memA_en,
  output logic                   memA_WrEn,
  output logic [$clog2(DIM)-1:0] Arow,
  output logic                   memB_en,
  output logic                   sa_clr,
  output logic                   sa_en,
  output logic [$clog2(DIM)-1:0] Crow,
  output logic                   Chalf,
  output logic                   busy,
  output logic                   done,
  output logic                   err_busy
);

  localparam int ROWW = $clog2(DIM);
  localparam int CNTW = $clog2(3 * DIM);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(run_cycles(DIM) - 1);

  // One host word must carry exactly one operand row
  if (DIM * BITS_AB != 64) begin : g_bad_pack
    $error("tpu_seq_ctrl: DIM*BITS_AB must equal 64");
  end

  state_t            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic              err_q;

  logic              a_wr, b_wr, c_rd, trig, mapped;
  logic [ROWW-1:0]   arow, crow;
  logic              chalf;
  logic              host_ok, run;

  tpu_addr_decode #(
    .DIM   (DIM),
    .ADDRW (ADDRW)
  ) u_dec (
    .host_valid_i (host_valid),
    .r_w_i        (r_w),
    .addr_i       (addr),
    .a_wr_o       (a_wr),
    .b_wr_o       (b_wr),
    .c_rd_o       (c_rd),
    .trig_o       (trig),
    .mapped_o     (mapped),
    .arow_o       (arow),
    .crow_o       (crow),
    .chalf_o      (chalf)
  );

  // Sequencer FSM: IDLE accepts a trigger, RUN streams the array, DONE pulses completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        RUN: begin
          if (mapped) err_q <= 1'b1;
          if (cnt_q == CNT_LAST) state_q <= DONE;
          else                   cnt_q   <= cnt_q + CNTW'(1);
        end
        DONE: begin
          if (mapped) err_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Host decode is visible only in IDLE and out of reset; RUN owns A, B and the array
  always_comb begin
    host_ok   = rst_n && (state_q == IDLE);
    run       = (state_q == RUN);
    memA_en   = run | (host_ok & a_wr);
    memA_WrEn = host_ok & a_wr;
    Arow      = host_ok ? arow : '0;
    memB_en   = run | (host_ok & b_wr);
    sa_clr    = host_ok & trig;
    sa_en     = run;
    Crow      = host_ok ? crow : '0;
    Chalf     = host_ok & chalf;
    busy      = (state_q == RUN) || (state_q == DONE);
    done      = (state_q == DONE);
    err_busy  = err_q;
  end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Testbench for tpu_seq_ctrl: decode table, hand-written sequences and a random run vs a phase model.
module tb_tpu_seq_ctrl;

  localparam int DIM  = 8;
  localparam int RUNC = 3 * DIM - 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        host_valid = 1'b0;
  logic        r_w = 1'b0;
  logic [15:0] addr = 16'h0;
  logic        memA_en, memA_WrEn, memB_en, sa_clr, sa_en, Chalf, busy, done, err_busy;
  logic [2:0]  Arow, Crow;

  always #5 clk = ~clk;

  tpu_seq_ctrl #(.BITS_AB(8), .DIM(DIM), .ADDRW(16)) dut (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .r_w(r_w), .addr(addr),
    .memA_en(memA_en), .memA_WrEn(memA_WrEn), .Arow(Arow), .memB_en(memB_en),
    .sa_clr(sa_clr), .sa_en(sa_en), .Crow(Crow), .Chalf(Chalf),
    .busy(busy), .done(done), .err_busy(err_busy)
  );

  typedef struct packed {
    logic       a_en;
    logic       a_wr;
    logic [2:0] arow;
    logic       b_en;
    logic       clr;
    logic       sa;
    logic [2:0] crow;
    logic       chalf;
    logic       busy;
    logic       done;
    logic       err;
  } outs_t;

  typedef struct {
    logic        hv;
    logic        rw;
    logic [15:0] a;
    outs_t       exp;
  } vec_t;

  int nchecks = 0;
  int nerr    = 0;
  // Reference model: phase 0 = idle, 1..RUNC = computing, RUNC+1 = done
  int ph   = 0;
  bit errm = 1'b0;

  function automatic outs_t actual();
    return {memA_en, memA_WrEn, Arow, memB_en, sa_clr, sa_en, Crow, Chalf, busy, done, err_busy};
  endfunction

  function automatic bit in_rng(logic [15:0] a, int lo, int hi);
    return (int'(a) >= lo) && (int'(a) <= hi);
  endfunction

  function automatic bit is_mapped(logic [15:0] a);
    return in_rng(a, 'h100, 'h13F) || in_rng(a, 'h200, 'h23F) || in_rng(a, 'h300, 'h37F) || (a == 16'h0400);
  endfunction

  function automatic outs_t mk(bit ae, bit aw, logic [2:0] ar, bit be, logic [2:0] cr, bit ch);
    outs_t o = '0;
    o.a_en = ae; o.a_wr = aw; o.arow = ar; o.b_en = be; o.crow = cr; o.chalf = ch;
    return o;
  endfunction

  function automatic outs_t model_out(int p, bit e, logic hv, logic rw, logic [15:0] a);
    outs_t o = '0;
    int off;
    o.err = e;
    if (p == 0) begin
      if (hv && rw && in_rng(a, 'h100, 'h13F)) begin
        off = int'(a) - 'h100;
        o.a_en = 1'b1; o.a_wr = 1'b1; o.arow = 3'(off / 8);
      end
      if (hv && rw && in_rng(a, 'h200, 'h23F)) o.b_en = 1'b1;
      if (hv && !rw && in_rng(a, 'h300, 'h37F)) begin
        off = int'(a) - 'h300;
        o.crow = 3'(off / 16); o.chalf = 1'((off / 8) % 2);
      end
      if (hv && rw && a == 16'h0400) o.clr = 1'b1;
    end else if (p <= RUNC) begin
      o.a_en = 1'b1; o.b_en = 1'b1; o.sa = 1'b1; o.busy = 1'b1;
    end else begin
      o.done = 1'b1; o.busy = 1'b1;
    end
    return o;
  endfunction

  task automatic model_step(logic hv, logic rw, logic [15:0] a);
    if (ph == 0) begin
      if (hv && rw && a == 16'h0400) begin
        ph = 1; errm = 1'b0;
      end
    end else begin
      if (hv && is_mapped(a)) errm = 1'b1;
      ph = (ph == RUNC + 1) ? 0 : ph + 1;
    end
  endtask

  task automatic chk(string nm, outs_t got, outs_t exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_int(string nm, int got, int exp);
    nchecks++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Entered at posedge+1: drive, sample at the falling edge, then advance the model
  task automatic cycle(logic hv, logic rw, logic [15:0] a, string nm, output outs_t got);
    host_valid = hv; r_w = rw; addr = a;
    #4;
    got = actual();
    chk(nm, got, model_out(ph, errm, hv, rw, a));
    @(posedge clk);
    model_step(hv, rw, a);
    #1;
  endtask

  task automatic do_reset(string nm);
    host_valid = 1'b0; r_w = 1'b0; addr = 16'h0;
    rst_n = 1'b0;
    #1;
    chk(nm, actual(), '0);
    ph = 0; errm = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[13];

  initial begin
    outs_t g;
    int run_cnt, done_cnt, done_at;
    logic        hv, rw;
    logic [15:0] a;

    tbl[0]  = '{1'b1, 1'b1, 16'h0118, mk(1, 1, 3'd3, 0, 3'd0, 0)};
    tbl[1]  = '{1'b1, 1'b1, 16'h0208, mk(0, 0, 3'd0, 1, 3'd0, 0)};
    tbl[2]  = '{1'b1, 1'b0, 16'h0358, mk(0, 0, 3'd0, 0, 3'd5, 1)};
    tbl[3]  = '{1'b1, 1'b1, 16'h0358, mk(0, 0, 3'd0, 0, 3'd0, 0)};
    tbl[4]  = '{1'b1, 1'b0, 16'h0118, mk(0, 0, 3'd0, 0, 3'd0, 0)};
    tbl[5]  = '{1'b0, 1'b1, 16'h0118, mk(0, 0, 3'd0, 0, 3'd0, 0)};
    tbl[6]  = '{1'b1, 1'b1, 16'h0500, mk(0, 0, 3'd0, 0, 3'd0, 0)};
    tbl[7]  = '{1'b1, 1'b0, 16'h0400, mk(0, 0, 3'd0, 0, 3'd0, 0)};
    tbl[8]  = '{1'b1, 1'b1, 16'h0138, mk(1, 1, 3'd7, 0, 3'd0, 0)};
    tbl[9]  = '{1'b1, 1'b0, 16'h0300, mk(0, 0, 3'd0, 0, 3'd0, 0)};
    tbl[10] = '{1'b1, 1'b0, 16'h0378, mk(0, 0, 3'd0, 0, 3'd7, 1)};
    tbl[11] = '{1'b1, 1'b0, 16'h0208, mk(0, 0, 3'd0, 0, 3'd0, 0)};
    tbl[12] = '{1'b1, 1'b1, 16'h0140, mk(0, 0, 3'd0, 0, 3'd0, 0)};

    // Reset asserted mid-cycle, then a few quiet cycles
    #7;
    do_reset("reset_async");
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 16'h0, "reset_quiet", g);

    // Idle decode table
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].hv, tbl[i].rw, tbl[i].a, $sformatf("tbl%0d_model", i), g);
      chk($sformatf("tbl%0d", i), g, tbl[i].exp);
    end

    // Full sequence and back-to-back retrigger
    cycle(1'b1, 1'b1, 16'h0400, "seq_trig", g);
    chk_int("seq_sa_clr", int'(g.clr), 1);
    run_cnt = 0; done_at = -1;
    for (int k = 1; k <= RUNC + 1; k++) begin
      cycle(1'b0, 1'b0, 16'h0, "seq_run", g);
      if (g.sa && g.a_en && g.b_en) run_cnt++;
      if (g.done) done_at = k;
    end
    chk_int("seq_run_len", run_cnt, RUNC);
    chk_int("seq_done_at", done_at, RUNC + 1);
    cycle(1'b1, 1'b1, 16'h0400, "seq_retrig", g);
    chk_int("seq_retrig_busy", int'(g.busy), 0);
    chk_int("seq_retrig_clr", int'(g.clr), 1);
    for (int k = 1; k <= RUNC + 1; k++) cycle(1'b0, 1'b0, 16'h0, "seq_run2", g);

    // Host traffic during busy
    cycle(1'b1, 1'b1, 16'h0400, "err_trig", g);
    for (int k = 1; k <= RUNC + 1; k++) begin
      hv = 1'b0; rw = 1'b0; a = 16'h0;
      if (k == 3) begin hv = 1'b1; rw = 1'b1; a = 16'h0500; end
      if (k == 5) begin hv = 1'b1; rw = 1'b1; a = 16'h0108; end
      if (k == 9) begin hv = 1'b1; rw = 1'b1; a = 16'h0400; end
      cycle(hv, rw, a, "err_run", g);
      if (k == 4) chk_int("err_unmapped_keeps0", int'(g.err), 0);
      if (k == 5) chk_int("err_no_wren", int'(g.a_wr), 0);
      if (k == 6) chk_int("err_set", int'(g.err), 1);
    end
    cycle(1'b0, 1'b0, 16'h0, "err_idle", g);
    chk_int("err_sticky", int'(g.err), 1);
    chk_int("err_dropped_trig", int'(g.busy), 0);
    cycle(1'b1, 1'b1, 16'h0400, "err_clr_trig", g);
    cycle(1'b0, 1'b0, 16'h0, "err_after_trig", g);
    chk_int("err_cleared", int'(g.err), 0);
    for (int k = 2; k <= RUNC + 1; k++) cycle(1'b0, 1'b0, 16'h0, "err_drain", g);

    // Reset in the middle of RUN, then a fresh full sequence
    cycle(1'b1, 1'b1, 16'h0400, "abort_trig", g);
    for (int k = 1; k < 10; k++) cycle(1'b0, 1'b0, 16'h0, "abort_run", g);
    do_reset("abort_reset");
    done_cnt = 0;
    for (int k = 0; k < RUNC + 4; k++) begin
      cycle(1'b0, 1'b0, 16'h0, "abort_quiet", g);
      if (g.done) done_cnt++;
    end
    chk_int("abort_no_done", done_cnt, 0);
    cycle(1'b1, 1'b1, 16'h0400, "abort_retrig", g);
    run_cnt = 0;
    for (int k = 1; k <= RUNC + 1; k++) begin
      cycle(1'b0, 1'b0, 16'h0, "abort_rerun", g);
      if (g.sa) run_cnt++;
    end
    chk_int("abort_rerun_len", run_cnt, RUNC);

    // Random traffic against the phase model
    for (int n = 0; n < 800; n++) begin
      hv = 1'($urandom_range(0, 3) != 0);
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: a = 16'h0100 + 16'(8 * $urandom_range(0, 7));
        1: a = 16'h0200 + 16'(8 * $urandom_range(0, 7));
        2: a = 16'h0300 + 16'(8 * $urandom_range(0, 15));
        3: begin a = 16'h0400; rw = 1'($urandom_range(0, 3) != 0); end
        4: a = 16'h0500;
        5: a = 16'h0140;
        default: a = 16'($urandom) & 16'hFFF8;
      endcase
      cycle(hv, rw, a, "rand", g);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
